// File: rtl/jcu_pkg.sv
// Shared constants for the jump control unit: flow-control opcodes, flag bit
// positions and the layout of a return-stack entry.
package jcu_pkg;

   localparam logic [4:0] OP_JC   = 5'b11100;
   localparam logic [4:0] OP_JNC  = 5'b11101;
   localparam logic [4:0] OP_JZ   = 5'b11110;
   localparam logic [4:0] OP_JNZ  = 5'b11111;
   localparam logic [4:0] OP_JMP  = 5'b11000;
   localparam logic [4:0] OP_CALL = 5'b11001;
   localparam logic [4:0] OP_RET  = 5'b10000;

   localparam int FLAG_CARRY = 0;
   localparam int FLAG_ZERO  = 1;
   localparam int FLAGS_W    = 2;

   // Entry = {is_irq, flags[1:0], addr[aw-1:0]}
   function automatic int entry_width(input int aw);
      return 1 + FLAGS_W + aw;
   endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO holding return frames; push and pop are never requested together.
module return_stack #(
   parameter int W     = 11,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic [W-1:0]                 push_data,
   output logic [W-1:0]                 top,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   depth
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [CW-1:0] count;
   logic [IW-1:0] wr_idx;
   logic [IW-1:0] rd_idx;

   assign wr_idx = count[IW-1:0];
   assign rd_idx = IW'(count - CW'(1));
   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);
   assign depth  = count;
   assign top    = empty ? '0 : mem[rd_idx];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && !full) begin
         mem[wr_idx] <= push_data;
         count       <= count + CW'(1);
      end else if (pop && !empty) begin
         count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/jump_control_unit.sv
// Resolves jumps, CALL/RET and prioritised interrupts for the execute stage
// and steers the fetch PC mux.
module jump_control_unit
   import jcu_pkg::*;
#(
   parameter int AW         = 8,
   parameter int DEPTH      = 4,
   parameter int NUM_IRQ    = 4,
   parameter int VEC_BASE   = 8'hF0,
   parameter int VEC_STRIDE = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [19:0]                  ins,
   input  logic [AW-1:0]                current_address,
   input  logic [3:0]                   flag_ex,
   input  logic [NUM_IRQ-1:0]           irq_req,
   output logic [NUM_IRQ-1:0]           irq_ack,
   output logic                         pc_mux_sel,
   output logic [AW-1:0]                jmp_loc,
   output logic [1:0]                   flag_restore,
   output logic                         flag_restore_valid,
   output logic                         int_enable,
   output logic [$clog2(DEPTH+1)-1:0]   stack_depth,
   output logic                         stack_err
);

   localparam int EW    = entry_width(AW);
   localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   logic [4:0]       opcode;
   logic [AW-1:0]    target;
   logic             is_call;
   logic             is_ret;
   logic             taken;
   logic             push;
   logic             pop;
   logic [EW-1:0]    push_data;
   logic [EW-1:0]    top;
   logic             full;
   logic             empty;
   logic             irq_accept;
   logic             dispatch_pending;
   logic [IDX_W-1:0] winner;
   logic [IDX_W-1:0] irq_idx;
   logic [AW-1:0]    vector;
   logic             unused_bits;

   assign opcode      = ins[19:15];
   assign target      = ins[AW-1:0];
   assign is_call     = (opcode == OP_CALL);
   assign is_ret      = (opcode == OP_RET);
   assign vector      = AW'(VEC_BASE) + AW'(irq_idx) * AW'(VEC_STRIDE);
   assign unused_bits = ^{ins[14:AW], flag_ex[3:2]};

   assign irq_accept = (|irq_req) && int_enable && !full && !is_call && !is_ret
                       && !dispatch_pending;

   always_comb begin
      winner = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (irq_req[i]) winner = IDX_W'(i);
      end
   end

   // A dispatch cycle redirects fetch, so the instruction decoded alongside
   // it has no effect at all (no jump, no stack traffic, no error).
   always_comb begin
      pc_mux_sel         = 1'b0;
      jmp_loc            = '0;
      flag_restore       = '0;
      flag_restore_valid = 1'b0;
      stack_err          = 1'b0;
      irq_ack            = '0;
      push               = 1'b0;
      pop                = 1'b0;
      push_data          = '0;
      taken              = 1'b0;
      if (dispatch_pending) begin
         pc_mux_sel = 1'b1;
         jmp_loc    = vector;
         irq_ack    = NUM_IRQ'(1) << irq_idx;
      end else begin
         case (opcode)
            OP_JC:   taken = flag_ex[FLAG_CARRY];
            OP_JNC:  taken = !flag_ex[FLAG_CARRY];
            OP_JZ:   taken = flag_ex[FLAG_ZERO];
            OP_JNZ:  taken = !flag_ex[FLAG_ZERO];
            OP_JMP:  taken = 1'b1;
            OP_CALL: begin
               if (!full) begin
                  push      = 1'b1;
                  push_data = {1'b0, flag_ex[1:0], current_address};
                  taken     = 1'b1;
               end else begin
                  stack_err = 1'b1;
               end
            end
            OP_RET: begin
               if (!empty) begin
                  pop                = 1'b1;
                  pc_mux_sel         = 1'b1;
                  jmp_loc            = top[AW-1:0];
                  flag_restore       = top[AW+1:AW];
                  flag_restore_valid = 1'b1;
               end else begin
                  stack_err = 1'b1;
               end
            end
            default: ;
         endcase
         if (taken) begin
            pc_mux_sel = 1'b1;
            jmp_loc    = target;
         end
         if (irq_accept) begin
            push      = 1'b1;
            push_data = {1'b1, flag_ex[1:0], current_address};
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         int_enable       <= 1'b1;
         dispatch_pending <= 1'b0;
         irq_idx          <= '0;
      end else begin
         dispatch_pending <= irq_accept;
         if (irq_accept) begin
            int_enable <= 1'b0;
            irq_idx    <= winner;
         end else if (pop && top[EW-1]) begin
            int_enable <= 1'b1;
         end
      end
   end

   return_stack #(.W(EW), .DEPTH(DEPTH)) u_stack (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_data (push_data),
      .top       (top),
      .full      (full),
      .empty     (empty),
      .depth     (stack_depth)
   );

endmodule

// File: tb/tb_jump_control_unit.sv
// Directed self-checking bench for jump_control_unit with hand-computed
// expectations for jumps, CALL/RET, interrupts and stack limits.
module tb_jump_control_unit;

   localparam logic [4:0] OP_JC   = 5'b11100;
   localparam logic [4:0] OP_JNC  = 5'b11101;
   localparam logic [4:0] OP_JZ   = 5'b11110;
   localparam logic [4:0] OP_JNZ  = 5'b11111;
   localparam logic [4:0] OP_JMP  = 5'b11000;
   localparam logic [4:0] OP_CALL = 5'b11001;
   localparam logic [4:0] OP_RET  = 5'b10000;
   localparam logic [4:0] OP_NOP  = 5'b00000;

   logic        clk = 1'b0;
   logic        reset;
   logic [19:0] ins;
   logic [7:0]  current_address;
   logic [3:0]  flag_ex;
   logic [3:0]  irq_req;
   logic [3:0]  irq_ack;
   logic        pc_mux_sel;
   logic [7:0]  jmp_loc;
   logic [1:0]  flag_restore;
   logic        flag_restore_valid;
   logic        int_enable;
   logic [2:0]  stack_depth;
   logic        stack_err;

   int compared   = 0;
   int mismatched = 0;

   jump_control_unit dut (
      .clk                (clk),
      .reset              (reset),
      .ins                (ins),
      .current_address    (current_address),
      .flag_ex            (flag_ex),
      .irq_req            (irq_req),
      .irq_ack            (irq_ack),
      .pc_mux_sel         (pc_mux_sel),
      .jmp_loc            (jmp_loc),
      .flag_restore       (flag_restore),
      .flag_restore_valid (flag_restore_valid),
      .int_enable         (int_enable),
      .stack_depth        (stack_depth),
      .stack_err          (stack_err)
   );

   always #5 clk = ~clk;

   function automatic logic [19:0] mkIns(input logic [4:0] op, input logic [7:0] tgt);
      return {op, 7'b0, tgt};
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] actual,
                              input logic [15:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive a full input vector and let the combinational outputs settle.
   task automatic applyStimulus(input logic [4:0] op, input logic [7:0] tgt,
                                input logic [7:0] addr, input logic [3:0] flags,
                                input logic [3:0] irq);
      ins             = mkIns(op, tgt);
      current_address = addr;
      flag_ex         = flags;
      irq_req         = irq;
      #1;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   logic [4:0] cond_op  [10] = '{OP_JC, OP_JC, OP_JNC, OP_JNC, OP_JZ, OP_JNZ,
                                 OP_JNZ, OP_JMP, OP_NOP, 5'b10001};
   logic [3:0] cond_fl  [10] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0010,
                                 4'b0000, 4'b0010, 4'b0011, 4'b0011, 4'b0000};
   logic       cond_exp [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                                 1'b1, 1'b0, 1'b0};

   initial begin
      reset = 1'b1;
      applyStimulus(OP_NOP, 8'h00, 8'h00, 4'h0, 4'h0);
      checkOutput("reset_pc_mux_sel", 16'(pc_mux_sel), 16'h0);
      checkOutput("reset_depth", 16'(stack_depth), 16'h0);
      checkOutput("reset_int_enable", 16'(int_enable), 16'h1);
      checkOutput("reset_irq_ack", 16'(irq_ack), 16'h0);
      checkOutput("reset_stack_err", 16'(stack_err), 16'h0);
      checkOutput("reset_restore_valid", 16'(flag_restore_valid), 16'h0);
      nextCycle();
      reset = 1'b0;
      nextCycle();

      applyStimulus(OP_JZ, 8'h3A, 8'h00, 4'b0010, 4'h0);
      checkOutput("jz_taken_sel", 16'(pc_mux_sel), 16'h1);
      checkOutput("jz_taken_loc", 16'(jmp_loc), 16'h3A);
      applyStimulus(OP_JZ, 8'h3A, 8'h00, 4'b0000, 4'h0);
      checkOutput("jz_not_taken_sel", 16'(pc_mux_sel), 16'h0);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(cond_op[i], 8'(8'h10 + i), 8'h00, cond_fl[i], 4'h0);
         checkOutput($sformatf("cond%0d_sel", i), 16'(pc_mux_sel), 16'(cond_exp[i]));
         if (cond_exp[i])
            checkOutput($sformatf("cond%0d_loc", i), 16'(jmp_loc), 16'(8'h10 + i));
      end
      nextCycle();

      applyStimulus(OP_CALL, 8'h40, 8'h12, 4'b0001, 4'h0);
      checkOutput("call_sel", 16'(pc_mux_sel), 16'h1);
      checkOutput("call_loc", 16'(jmp_loc), 16'h40);
      nextCycle();
      applyStimulus(OP_NOP, 8'h00, 8'h41, 4'h0, 4'h0);
      checkOutput("call_depth", 16'(stack_depth), 16'h1);
      nextCycle();
      applyStimulus(OP_RET, 8'h00, 8'h42, 4'h0, 4'h0);
      checkOutput("ret_sel", 16'(pc_mux_sel), 16'h1);
      checkOutput("ret_loc", 16'(jmp_loc), 16'h12);
      checkOutput("ret_flags", 16'(flag_restore), 16'h1);
      checkOutput("ret_flags_valid", 16'(flag_restore_valid), 16'h1);
      nextCycle();
      applyStimulus(OP_NOP, 8'h00, 8'h00, 4'h0, 4'h0);
      checkOutput("ret_depth", 16'(stack_depth), 16'h0);
      checkOutput("ret_call_int_enable", 16'(int_enable), 16'h1);
      checkOutput("ret_valid_pulse", 16'(flag_restore_valid), 16'h0);

      applyStimulus(OP_NOP, 8'h00, 8'h20, 4'h0, 4'b0110);
      checkOutput("irq_accept_sel", 16'(pc_mux_sel), 16'h0);
      nextCycle();
      applyStimulus(OP_NOP, 8'h00, 8'h21, 4'h0, 4'h0);
      checkOutput("irq_disp_sel", 16'(pc_mux_sel), 16'h1);
      checkOutput("irq_disp_loc", 16'(jmp_loc), 16'hF4);
      checkOutput("irq_disp_ack", 16'(irq_ack), 16'h2);
      checkOutput("irq_disp_int_enable", 16'(int_enable), 16'h0);
      checkOutput("irq_disp_depth", 16'(stack_depth), 16'h1);
      nextCycle();
      checkOutput("irq_ack_pulse", 16'(irq_ack), 16'h0);
      checkOutput("irq_after_disp_sel", 16'(pc_mux_sel), 16'h0);
      applyStimulus(OP_RET, 8'h00, 8'h22, 4'h0, 4'h0);
      checkOutput("irq_ret_loc", 16'(jmp_loc), 16'h20);
      nextCycle();
      applyStimulus(OP_NOP, 8'h00, 8'h00, 4'h0, 4'h0);
      checkOutput("irq_ret_int_enable", 16'(int_enable), 16'h1);

      applyStimulus(OP_CALL, 8'h50, 8'h33, 4'h0, 4'h0);
      nextCycle();
      applyStimulus(OP_RET, 8'h00, 8'h34, 4'h0, 4'b0001);
      checkOutput("retirq_ret_loc", 16'(jmp_loc), 16'h33);
      checkOutput("retirq_no_ack", 16'(irq_ack), 16'h0);
      nextCycle();
      applyStimulus(OP_NOP, 8'h00, 8'h34, 4'h0, 4'b0001);
      checkOutput("retirq_deferred_sel", 16'(pc_mux_sel), 16'h0);
      checkOutput("retirq_deferred_depth", 16'(stack_depth), 16'h0);
      nextCycle();
      applyStimulus(OP_NOP, 8'h00, 8'h35, 4'h0, 4'h0);
      checkOutput("retirq_disp_loc", 16'(jmp_loc), 16'hF0);
      checkOutput("retirq_disp_ack", 16'(irq_ack), 16'h1);
      nextCycle();
      applyStimulus(OP_RET, 8'h00, 8'h36, 4'h0, 4'h0);
      checkOutput("retirq_back_loc", 16'(jmp_loc), 16'h34);
      nextCycle();

      applyStimulus(OP_JC, 8'h70, 8'h45, 4'b0001, 4'b0100);
      checkOutput("jcirq_sel", 16'(pc_mux_sel), 16'h1);
      checkOutput("jcirq_loc", 16'(jmp_loc), 16'h70);
      nextCycle();
      applyStimulus(OP_NOP, 8'h00, 8'h70, 4'h0, 4'h0);
      checkOutput("jcirq_disp_loc", 16'(jmp_loc), 16'hF8);
      checkOutput("jcirq_disp_ack", 16'(irq_ack), 16'h4);
      nextCycle();
      applyStimulus(OP_RET, 8'h00, 8'h00, 4'h0, 4'h0);
      checkOutput("jcirq_ret_loc", 16'(jmp_loc), 16'h45);
      checkOutput("jcirq_ret_flags", 16'(flag_restore), 16'h1);
      nextCycle();

      for (int i = 0; i < 4; i++) begin
         applyStimulus(OP_CALL, 8'(8'h80 + i), 8'(8'h60 + i), 4'h0, 4'h0);
         checkOutput($sformatf("fill%0d_sel", i), 16'(pc_mux_sel), 16'h1);
         nextCycle();
      end
      applyStimulus(OP_CALL, 8'h90, 8'h64, 4'h0, 4'h0);
      checkOutput("full_depth", 16'(stack_depth), 16'h4);
      checkOutput("overflow_err", 16'(stack_err), 16'h1);
      checkOutput("overflow_sel", 16'(pc_mux_sel), 16'h0);
      nextCycle();
      applyStimulus(OP_NOP, 8'h00, 8'h65, 4'h0, 4'b0001);
      checkOutput("full_irq_no_err", 16'(stack_err), 16'h0);
      nextCycle();
      checkOutput("full_irq_held_ack", 16'(irq_ack), 16'h0);
      checkOutput("full_irq_held_sel", 16'(pc_mux_sel), 16'h0);
      checkOutput("full_irq_depth", 16'(stack_depth), 16'h4);
      for (int i = 3; i >= 0; i--) begin
         applyStimulus(OP_RET, 8'h00, 8'h00, 4'h0, 4'h0);
         checkOutput($sformatf("unwind%0d_loc", i), 16'(jmp_loc), 16'(8'h60 + i));
         nextCycle();
      end
      applyStimulus(OP_RET, 8'h00, 8'h00, 4'h0, 4'h0);
      checkOutput("underflow_err", 16'(stack_err), 16'h1);
      checkOutput("underflow_sel", 16'(pc_mux_sel), 16'h0);
      checkOutput("underflow_depth", 16'(stack_depth), 16'h0);
      nextCycle();

      applyStimulus(OP_NOP, 8'h00, 8'h77, 4'h0, 4'b1000);
      nextCycle();
      reset = 1'b1;
      #1;
      checkOutput("midreset_ack", 16'(irq_ack), 16'h0);
      checkOutput("midreset_sel", 16'(pc_mux_sel), 16'h0);
      checkOutput("midreset_depth", 16'(stack_depth), 16'h0);
      checkOutput("midreset_int_enable", 16'(int_enable), 16'h1);
      applyStimulus(OP_NOP, 8'h00, 8'h00, 4'h0, 4'h0);
      reset = 1'b0;
      #1;
      checkOutput("post_reset_ack", 16'(irq_ack), 16'h0);
      nextCycle();
      checkOutput("post_reset_sel", 16'(pc_mux_sel), 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
